// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: one CHUNK-bit slice resolved per stage, carry registered between
// slices, with a single global advance enable driving valid/ready flow control.
module pipelined_addsub #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned STAGES = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
   localparam int unsigned LAST   = STAGES - 1;
   localparam int unsigned REM    = (CHUNK == 0) ? 0 : WIDTH % CHUNK;

   if (CHUNK == 0 || REM != 0) begin : g_param_check
      $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
   end

   logic             valid_q [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic             carry_q [STAGES];
   logic             ovf_q;

   // Stage inputs: conditioned ports for stage 0, previous stage registers otherwise.
   logic             st_v    [STAGES];
   logic [WIDTH-1:0] st_a    [STAGES];
   logic [WIDTH-1:0] st_b    [STAGES];
   logic [WIDTH-1:0] st_s    [STAGES];
   logic             st_c    [STAGES];
   logic [CHUNK:0]   part    [STAGES];
   logic [WIDTH-1:0] nx_s    [STAGES];
   logic             nx_c    [STAGES];
   logic             adv;
   logic             ovf_d;

   assign adv = !valid_q[LAST] || out_ready;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_first
         assign st_v[g] = in_valid;
         assign st_a[g] = a;
         assign st_b[g] = sub ? ~b : b;
         assign st_s[g] = '0;
         assign st_c[g] = sub | cin;
      end else begin : g_next
         assign st_v[g] = valid_q[g-1];
         assign st_a[g] = a_q[g-1];
         assign st_b[g] = b_q[g-1];
         assign st_s[g] = sum_q[g-1];
         assign st_c[g] = carry_q[g-1];
      end

      assign part[g] = {1'b0, st_a[g][g*CHUNK +: CHUNK]}
                     + {1'b0, st_b[g][g*CHUNK +: CHUNK]}
                     + (CHUNK+1)'(st_c[g]);
      // Slices above g are still zero in st_s, so OR-ing drops this slice into place.
      assign nx_s[g] = st_s[g] | (WIDTH'(part[g][CHUNK-1:0]) << (g * CHUNK));
      assign nx_c[g] = part[g][CHUNK];
   end

   assign ovf_d = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1])
               && (nx_s[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            sum_q[k]   <= '0;
            carry_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            valid_q[k] <= st_v[k];
            // Bubbles keep the old data so idle stages do not toggle.
            if (st_v[k]) begin
               a_q[k]     <= st_a[k];
               b_q[k]     <= st_b[k];
               sum_q[k]   <= nx_s[k];
               carry_q[k] <= nx_c[k];
            end
         end
         if (st_v[LAST]) begin
            ovf_q <= ovf_d;
         end
      end
   end

   assign in_ready  = adv;
   assign out_valid = valid_q[LAST];
   assign sum       = sum_q[LAST];
   assign cout      = carry_q[LAST];
   assign ovf       = ovf_q;

endmodule
